uart_rx: RTL

//   Serial-to-parallel UART receiver, 8N1 framing, LSB first, fixed BAUD_DIV clocks per bit.
//   It is the receive half of uart_top and sits beside uart_tx: pin rx -> data_out/rx_done.
//   It synchronises the asynchronous rx pin, qualifies the start bit at mid-bit,

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: rx pin in, assembled byte plus status pulses out.
// The receiver takes the slave view; whoever drives the pin takes the master view.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  modport master (
    output rx,
    input  data_out, rx_done, frame_err, parity_err, rx_busy
  );

  modport slave (
    input  rx,
    output data_out, rx_done, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver (LSB first, BAUD_DIV clk/bit); optional parity bit with macro UART_RX_PARITY_EN.
// Latency: pin->rx_s 2 clk; rx_done/frame_err/parity_err pulse 1 clk after the mid-stop-bit sample.
// No backpressure: the line cannot be stalled, so data_out must be taken on the pulse cycle.
module uart_rx #(
  parameter int BAUD_DIV   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  localparam int             CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  if (BAUD_DIV < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx: BAUD_DIV must be >= 4 and PARITY_ODD 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          rx_meta, rx_s, rx_prev;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  // Synchroniser and edge history idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + CW'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        // Only a real falling edge starts a frame; a held-low line (break) is ignored.
        if (rx_prev && !rx_s) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_q == HALF) begin
          baud_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (baud_q == LAST) begin
          baud_d  = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_q == LAST) begin
          baud_d    = '0;
          par_bad_d = (rx_s != (^shreg_q ^ PARITY_ODD[0]));
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
        if (baud_q == LAST) begin
          baud_d  = '0;
          data_d  = shreg_q;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.rx_done    = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
